// File: rtl/uart_pkg.sv
// Shared types for the UART buffering controller.
//   byte_t     : one serial byte
//   tx_state_t : transmit launch sequencer states
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_GUARD
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Circular byte buffer with 2^LEN_WIDTH slots; one slot is kept unused so
// the occupancy count never wraps (usable capacity 2^LEN_WIDTH-1).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_data this edge (ignored when full)
//   push_data   : byte to write
//   pop         : drop the head entry this edge (ignored when empty)
//   head        : oldest entry
//   count       : registered occupancy
//   full, empty : occupancy flags derived from count
module uart_fifo
  import uart_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  byte_t                push_data,
  input  logic                 pop,
  output byte_t                head,
  output logic [LEN_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned DEPTH = 1 << LEN_WIDTH;

  byte_t                mem [DEPTH];
  logic [LEN_WIDTH-1:0] wr_ptr;
  logic [LEN_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  // Full/empty come from the pre-edge count, so a same-edge pop never
  // makes room for a push.
  assign full    = (count == '1);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_controller.sv
// Byte buffering between the UART receiver/transmitter and the core.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   recv_reset, trans_reset       : reset passed through to the PHY blocks
//   recv_data, recv_ok            : byte from receiver, one per high cycle
//   trans_data, trans_ok          : byte and one-cycle start pulse to transmitter
//   trans_busy                    : transmitter is sending
//   uart_in_data, uart_in_valid   : byte offered by the core for transmission
//   uart_in_ready                 : one-cycle acceptance pulse
//   uart_out_valid                : core requests a received byte
//   uart_out_data, uart_out_ready : delivered byte and one-cycle delivery pulse
//   in_buffer_length              : transmit FIFO occupancy
//   out_buffer_length             : receive FIFO occupancy
//   lost                          : sticky receive-overflow flag
module uart_controller
  import uart_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 recv_reset,
  input  byte_t                recv_data,
  input  logic                 recv_ok,
  output logic                 trans_reset,
  output byte_t                trans_data,
  output logic                 trans_ok,
  input  logic                 trans_busy,
  input  byte_t                uart_in_data,
  input  logic                 uart_in_valid,
  output logic                 uart_in_ready,
  input  logic                 uart_out_valid,
  output byte_t                uart_out_data,
  output logic                 uart_out_ready,
  output logic [LEN_WIDTH-1:0] in_buffer_length,
  output logic [LEN_WIDTH-1:0] out_buffer_length,
  output logic                 lost
);

  byte_t     rx_head;
  logic      rx_full;
  logic      rx_empty;
  logic      deliver;

  byte_t     tx_head;
  logic      tx_full;
  logic      tx_empty;
  logic      accept;
  logic      launch;
  tx_state_t tx_state;

  assign recv_reset  = reset;
  assign trans_reset = reset;

  // Gating on the current pulse value forces a dead cycle between
  // transfers, so a level-held request/offer is served every other cycle.
  assign deliver = uart_out_valid && !rx_empty && !uart_out_ready;
  assign accept  = uart_in_valid && !tx_full && !uart_in_ready;
  assign launch  = (tx_state == TX_IDLE) && !tx_empty && !trans_busy;

  uart_fifo #(.LEN_WIDTH(LEN_WIDTH)) rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (recv_ok),
    .push_data (recv_data),
    .pop       (deliver),
    .head      (rx_head),
    .count     (out_buffer_length),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  uart_fifo #(.LEN_WIDTH(LEN_WIDTH)) tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (uart_in_data),
    .pop       (launch),
    .head      (tx_head),
    .count     (in_buffer_length),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      uart_out_ready <= 1'b0;
      uart_out_data  <= '0;
      uart_in_ready  <= 1'b0;
      lost           <= 1'b0;
    end else begin
      uart_out_ready <= deliver;
      if (deliver) begin
        uart_out_data <= rx_head;
      end
      uart_in_ready <= accept;
      if (recv_ok && rx_full) begin
        lost <= 1'b1;
      end
    end
  end

  // GUARD gives the transmitter a cycle to raise trans_busy before the
  // next launch decision.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      trans_ok   <= 1'b0;
      trans_data <= '0;
    end else begin
      trans_ok <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (launch) begin
            tx_state   <= TX_START;
            trans_ok   <= 1'b1;
            trans_data <= tx_head;
          end
        end
        TX_START: tx_state <= TX_GUARD;
        TX_GUARD: tx_state <= TX_IDLE;
        default:  tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_controller.sv
// Scoreboard bench for uart_controller: expected bytes are queued when
// stimulus is issued and popped by a monitor on every delivery/launch pulse.
module tb_uart_controller;
  import uart_pkg::*;

  localparam int unsigned LW = 3;

  logic          clk;
  logic          reset;
  logic          recv_reset;
  byte_t         recv_data;
  logic          recv_ok;
  logic          trans_reset;
  byte_t         trans_data;
  logic          trans_ok;
  logic          trans_busy;
  byte_t         uart_in_data;
  logic          uart_in_valid;
  logic          uart_in_ready;
  logic          uart_out_valid;
  byte_t         uart_out_data;
  logic          uart_out_ready;
  logic [LW-1:0] in_buffer_length;
  logic [LW-1:0] out_buffer_length;
  logic          lost;

  uart_controller #(.LEN_WIDTH(LW)) dut (
    .clk               (clk),
    .reset             (reset),
    .recv_reset        (recv_reset),
    .recv_data         (recv_data),
    .recv_ok           (recv_ok),
    .trans_reset       (trans_reset),
    .trans_data        (trans_data),
    .trans_ok          (trans_ok),
    .trans_busy        (trans_busy),
    .uart_in_data      (uart_in_data),
    .uart_in_valid     (uart_in_valid),
    .uart_in_ready     (uart_in_ready),
    .uart_out_valid    (uart_out_valid),
    .uart_out_data     (uart_out_data),
    .uart_out_ready    (uart_out_ready),
    .in_buffer_length  (in_buffer_length),
    .out_buffer_length (out_buffer_length),
    .lost              (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    total;
  int    bad;
  int    in_ready_cnt;
  int    tx_launch_cnt;
  byte_t rx_exp[$];
  byte_t tx_exp[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Core-side offer: hold valid until an acceptance pulse or 4 edges.
  task automatic offer(input byte_t b, output logic acc);
    acc           = 1'b0;
    uart_in_valid = 1'b1;
    uart_in_data  = b;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (uart_in_ready) begin
        acc = 1'b1;
        break;
      end
    end
    uart_in_valid = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic  acc;
    int    n_acc;
    int    c0;
    int    l0;
    byte_t b;
    logic  prev_out_ready;
    logic  prev_trans_ok;

    total = 0; bad = 0; in_ready_cnt = 0; tx_launch_cnt = 0;
    prev_out_ready = 1'b0;
    prev_trans_ok  = 1'b0;
    reset = 1'b1; recv_data = '0; recv_ok = 1'b0; trans_busy = 1'b0;
    uart_in_data = '0; uart_in_valid = 1'b0; uart_out_valid = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (uart_out_ready) begin
            total++;
            if (prev_out_ready) begin
              bad++;
              $display("FAIL rx_pulse_width: uart_out_ready high two cycles, expected one");
            end
            if (rx_exp.size() == 0) begin
              bad++;
              $display("FAIL rx_unexpected: got byte %0h, expected no delivery", uart_out_data);
            end else if (uart_out_data !== rx_exp[0]) begin
              bad++;
              $display("FAIL rx_data: got %0h expected %0h", uart_out_data, rx_exp[0]);
              void'(rx_exp.pop_front());
            end else begin
              void'(rx_exp.pop_front());
            end
          end
          if (trans_ok) begin
            total++;
            tx_launch_cnt++;
            if (prev_trans_ok) begin
              bad++;
              $display("FAIL tx_pulse_width: trans_ok high two cycles, expected one");
            end
            if (tx_exp.size() == 0) begin
              bad++;
              $display("FAIL tx_unexpected: got byte %0h, expected no launch", trans_data);
            end else if (trans_data !== tx_exp[0]) begin
              bad++;
              $display("FAIL tx_data: got %0h expected %0h", trans_data, tx_exp[0]);
              void'(tx_exp.pop_front());
            end else begin
              void'(tx_exp.pop_front());
            end
          end
          if (uart_in_ready) in_ready_cnt++;
        end
        prev_out_ready = uart_out_ready && !reset;
        prev_trans_ok  = trans_ok && !reset;
      end
    join_none

    // Reset
    #1;
    chk("recv_reset_hi", recv_reset, 1);
    chk("trans_reset_hi", trans_reset, 1);
    tick();
    chk("rst_out_ready", uart_out_ready, 0);
    chk("rst_in_ready", uart_in_ready, 0);
    chk("rst_trans_ok", trans_ok, 0);
    chk("rst_lost", lost, 0);
    chk("rst_out_data", uart_out_data, 0);
    chk("rst_trans_data", trans_data, 0);
    chk("rst_in_len", in_buffer_length, 0);
    chk("rst_out_len", out_buffer_length, 0);
    reset = 1'b0;
    tick();
    chk("recv_reset_lo", recv_reset, 0);
    chk("trans_reset_lo", trans_reset, 0);

    // Receive and drain
    recv_ok = 1'b1; recv_data = 8'hB3; rx_exp.push_back(8'hB3); tick();
    recv_data = 8'h5F; rx_exp.push_back(8'h5F); tick();
    recv_ok = 1'b0; tick();
    recv_ok = 1'b1; recv_data = 8'hAA; rx_exp.push_back(8'hAA); tick();
    recv_ok = 1'b0;
    chk("rx_len3", out_buffer_length, 3);
    uart_out_valid = 1'b1;
    tick(); chk("alt_1", uart_out_ready, 1);
    tick(); chk("alt_0", uart_out_ready, 0);
    tick(); chk("alt_1b", uart_out_ready, 1);
    uart_out_valid = 1'b0;
    tick(); chk("drop_valid", uart_out_ready, 0);
    chk("rx_len1", out_buffer_length, 1);
    recv_ok = 1'b1; recv_data = 8'h0F; rx_exp.push_back(8'h0F); tick();
    recv_ok = 1'b0;
    uart_out_valid = 1'b1;
    repeat (6) tick();
    chk("rx_idle", uart_out_ready, 0);
    uart_out_valid = 1'b0;
    chk("rx_drained", rx_exp.size(), 0);
    chk("rx_len0", out_buffer_length, 0);
    chk("no_lost_yet", lost, 0);

    // Receive overflow
    recv_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = (i < 4) ? 8'hB3 : 8'h4C;
      recv_data = b;
      if (i < 7) rx_exp.push_back(b);
      tick();
    end
    recv_ok = 1'b0;
    chk("ovf_len7", out_buffer_length, 7);
    chk("ovf_lost", lost, 1);
    uart_out_valid = 1'b1;
    repeat (20) tick();
    uart_out_valid = 1'b0;
    chk("ovf_drained", rx_exp.size(), 0);
    chk("ovf_lost_sticky", lost, 1);

    // Transmit
    trans_busy = 1'b0;
    c0 = in_ready_cnt; l0 = tx_launch_cnt;
    tx_exp.push_back(8'h5A);
    uart_in_valid = 1'b1; uart_in_data = 8'h5A;
    tick(); tick();
    uart_in_valid = 1'b0;
    repeat (4) tick();
    chk("tx_one_accept", in_ready_cnt - c0, 1);
    chk("tx_one_launch", tx_launch_cnt - l0, 1);
    trans_busy = 1'b1;
    offer(8'h33, acc);
    chk("tx_busy_accept", acc, 1);
    repeat (8) tick();
    chk("tx_busy_hold", tx_launch_cnt - l0, 1);
    chk("tx_busy_len", in_buffer_length, 1);
    tx_exp.push_back(8'h33);
    trans_busy = 1'b0;
    repeat (5) tick();
    chk("tx_release", tx_exp.size(), 0);

    // Transmit backpressure
    trans_busy = 1'b1;
    c0 = in_ready_cnt; n_acc = 0;
    for (int i = 0; i < 9; i++) begin
      b = 8'h10 + 8'(i);
      offer(b, acc);
      if (acc) begin
        n_acc++;
        tx_exp.push_back(b);
      end
    end
    chk("bp_accepted", n_acc, 7);
    chk("bp_ready_pulses", in_ready_cnt - c0, 7);
    chk("bp_len7", in_buffer_length, 7);
    chk("bp_ready_lo", uart_in_ready, 0);
    trans_busy = 1'b0;
    repeat (30) tick();
    chk("bp_drained", tx_exp.size(), 0);
    chk("bp_len0", in_buffer_length, 0);

    // Simultaneous push and delivery on the receive FIFO
    recv_ok = 1'b1;
    recv_data = 8'h11; rx_exp.push_back(8'h11); tick();
    recv_data = 8'h22; rx_exp.push_back(8'h22); tick();
    recv_data = 8'h33; rx_exp.push_back(8'h33); uart_out_valid = 1'b1; tick();
    recv_ok = 1'b0; uart_out_valid = 1'b0;
    chk("sim_rx_deliver", uart_out_ready, 1);
    chk("sim_rx_len", out_buffer_length, 2);

    // Receive push, transmit accept and launch on one edge
    trans_busy = 1'b1;
    offer(8'h44, acc);
    chk("sim_pre_accept", acc, 1);
    tx_exp.push_back(8'h44);
    tick();
    trans_busy = 1'b0;
    recv_ok = 1'b1; recv_data = 8'h55; rx_exp.push_back(8'h55);
    uart_in_valid = 1'b1; uart_in_data = 8'h66; tx_exp.push_back(8'h66);
    tick();
    recv_ok = 1'b0; uart_in_valid = 1'b0;
    chk("sim_trans_ok", trans_ok, 1);
    chk("sim_in_ready", uart_in_ready, 1);
    chk("sim_in_len", in_buffer_length, 1);
    chk("sim_out_len", out_buffer_length, 3);
    uart_out_valid = 1'b1;
    repeat (12) tick();
    uart_out_valid = 1'b0;
    repeat (4) tick();
    chk("sim_rx_done", rx_exp.size(), 0);
    chk("sim_tx_done", tx_exp.size(), 0);

    // Reset mid-operation discards queued bytes
    recv_ok = 1'b1; recv_data = 8'h77; tick();
    recv_data = 8'h88; tick();
    recv_ok = 1'b0;
    trans_busy = 1'b1;
    offer(8'h99, acc);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("mid_rst_out_len", out_buffer_length, 0);
    chk("mid_rst_in_len", in_buffer_length, 0);
    chk("mid_rst_lost", lost, 0);
    trans_busy = 1'b0; uart_out_valid = 1'b1;
    repeat (8) tick();
    uart_out_valid = 1'b0;
    chk("mid_rst_no_rx", uart_out_ready, 0);
    chk("mid_rst_no_tx", trans_ok, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
